ro_freq_counter: RTL and testbench

- Downstream consumer of the ring oscillator in the rp_counter reconfigurable partition.
- Drives the oscillator's Enable and counts rising edges of its Clk_out over a programmable gate window of system clock cycles.
- Returns the count through a valid/ack handshake for the bus-side register logic.
- Treats Ro_in as fully asynchronous. It is synchronised and edge-detected in the single Clk domain. Rated for oscillator frequencies below Clk/4.

---
 rtl/ro_freq_counter.sv | 139 +++++++++++++
 tb/tb_ro_freq_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
`timescale 1ns/1ps
// ro_freq_counter
//   Measures a ring oscillator by counting rising edges of its output over a
//   programmable window of Clk cycles. Ro_in is asynchronous: it is
//   synchronised and edge-detected in the Clk domain, so the oscillator must
//   run below Clk/4.
//
//   Sequence: IDLE -> SETTLE (SETTLE_CYCLES, oscillator enabled, edges ignored)
//             -> MEASURE (gate cycles, edges counted) -> DONE (result held
//             until Count_ack) -> IDLE.
//
// Ports
//   Clk, Reset       system clock, async active-high reset
//   Start            measurement request, accepted only in IDLE
//   Gate_cycles      window length in Clk cycles, latched on accepted Start
//   Ro_in            oscillator output (asynchronous)
//   Ro_enable        registered oscillator enable
//   Busy             high in SETTLE and MEASURE
//   Count, Overflow  result, qualified by Count_valid
//   Count_valid      result available, held until Count_ack
//   Count_ack        consumer acknowledge
module ro_freq_counter #(
  parameter int GATE_WIDTH    = 24,
  parameter int COUNT_WIDTH   = 24,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [GATE_WIDTH-1:0]  Gate_cycles,
  input  logic                   Ro_in,
  output logic                   Ro_enable,
  output logic                   Busy,
  output logic [COUNT_WIDTH-1:0] Count,
  output logic                   Overflow,
  output logic                   Count_valid,
  input  logic                   Count_ack
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ro_s, ro_prev, rise;
  logic [SW-1:0]          settle_cnt;
  logic [GATE_WIDTH-1:0]  gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt, edge_nxt;
  logic                   ovf_run, ovf_nxt;
  logic                   settle_end, gate_end;

  assign ro_s       = sync_q[SYNC_STAGES-1];
  assign rise       = ro_s & ~ro_prev;
  assign settle_end = (settle_cnt == '0);
  // gate_cnt counts down from G to 1 in MEASURE, so G=0 never enters it.
  assign gate_end   = (gate_cnt == GATE_WIDTH'(1));
  assign Busy       = (state == SETTLE) || (state == MEASURE);

  // Saturating edge counter: a rise arriving at all-ones is lost and flagged.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_run;
    if (rise) begin
      if (&edge_cnt) ovf_nxt  = 1'b1;
      else           edge_nxt = edge_cnt + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start)      state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = (gate_cnt == '0) ? DONE : MEASURE;
      MEASURE: if (gate_end)   state_nxt = DONE;
      DONE:    if (Count_ack)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q      <= '0;
      ro_prev     <= 1'b0;
      settle_cnt  <= '0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf_run     <= 1'b0;
      Ro_enable   <= 1'b0;
      Count       <= '0;
      Overflow    <= 1'b0;
      Count_valid <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], Ro_in};
      ro_prev <= ro_s;
      unique case (state)
        IDLE: if (Start) begin
          gate_cnt   <= Gate_cycles;
          settle_cnt <= SETTLE_LAST;
          edge_cnt   <= '0;
          ovf_run    <= 1'b0;
          Overflow   <= 1'b0;
          Ro_enable  <= 1'b1;
        end
        SETTLE: begin
          if (!settle_end) settle_cnt <= settle_cnt - SW'(1);
          else if (gate_cnt == '0) begin
            Count       <= '0;
            Overflow    <= 1'b0;
            Count_valid <= 1'b1;
            Ro_enable   <= 1'b0;
          end
        end
        MEASURE: begin
          edge_cnt <= edge_nxt;
          ovf_run  <= ovf_nxt;
          gate_cnt <= gate_cnt - GATE_WIDTH'(1);
          // Result includes a rise seen in the final gate cycle.
          if (gate_end) begin
            Count       <= edge_nxt;
            Overflow    <= ovf_nxt;
            Count_valid <= 1'b1;
            Ro_enable   <= 1'b0;
          end
        end
        DONE: if (Count_ack) Count_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
`timescale 1ns/1ps
module tb_ro_freq_counter;

  localparam int GW   = 24;
  localparam int CW   = 8;
  localparam int S    = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          Clk, Reset, Start, Ro_in, Ro_enable, Busy, Overflow, Count_valid, Count_ack;
  logic [GW-1:0] Gate_cycles;
  logic [CW-1:0] Count;

  int  n_cmp = 0, n_bad = 0;
  logic ro_sq, ro_lvl, ro_wave_on;
  real ro_half = 50.011;

  ro_freq_counter #(.GATE_WIDTH(GW), .COUNT_WIDTH(CW), .SYNC_STAGES(2), .SETTLE_CYCLES(S)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Gate_cycles(Gate_cycles), .Ro_in(Ro_in),
    .Ro_enable(Ro_enable), .Busy(Busy), .Count(Count), .Overflow(Overflow),
    .Count_valid(Count_valid), .Count_ack(Count_ack));

  initial begin Clk = 0; forever #5 Clk = ~Clk; end

  // free-running oscillator, phase deliberately unrelated to Clk
  initial begin ro_sq = 0; #3.37; forever begin #(ro_half); ro_sq = ~ro_sq; end end
  assign Ro_in = ro_wave_on ? ro_sq : ro_lvl;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time expired, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
    n_cmp++;
    if (got < exp - tol || got > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference: a window of g cycles on a period-p wave holds g/p rising edges,
  // reported within +/-1, or saturated with overflow when far above CMAX.
  function automatic void model(input int g, input int p, output longint c,
                                output longint o, output longint tol);
    if (longint'(g) > (CMAX + 1) * p) begin c = CMAX; o = 1; tol = 0; end
    else begin c = (g + p / 2) / p; o = 0; tol = 1; end
  endfunction

  task automatic set_period(input int p);
    ro_half = p * 5.0 + 0.011;
  endtask

  // mode 0: wave, 1: constant level, 2: pulses before / inside / after window
  task automatic measure(input int g, input int mode, input int hold,
                         output longint cnt, output longint ovf);
    int n; bit run_bad, hold_bad;
    run_bad = 0; hold_bad = 0;
    @(posedge Clk); #1;
    chk("idle_en", Ro_enable, 0, 0);
    Gate_cycles = GW'(g); Start = 1;
    @(posedge Clk); #1;
    Start = 0; n = 1;
    while (!Count_valid && n < 1 + S + g + 20) begin
      if (Ro_enable !== 1'b1 || Busy !== 1'b1) run_bad = 1;
      if (mode == 2) ro_lvl = (n >= 5 && n < 8) || (n >= S + 10 && n < S + 13);
      Start       = (n == S + g / 2);
      Count_ack   = (n == 5);
      Gate_cycles = GW'($urandom);
      @(posedge Clk); #1;
      n++;
    end
    Start = 0; Count_ack = 0;
    chk("latency", n, 1 + S + g, 0);
    chk("run_en_busy", run_bad, 0, 0);
    chk("done_en", Ro_enable, 0, 0);
    chk("done_busy", Busy, 0, 0);
    cnt = longint'(Count); ovf = longint'(Overflow);
    for (int h = 0; h < hold; h++) begin
      Start = 1'($urandom_range(0, 1));
      if (mode == 2) ro_lvl = (h >= 2 && h < 5);
      @(posedge Clk); #1;
      if (Count !== CW'(cnt) || Overflow !== ovf[0] || Count_valid !== 1'b1 || Busy !== 1'b0)
        hold_bad = 1;
    end
    chk("hold_stable", hold_bad, 0, 0);
    Count_ack = 1; Start = 1;
    @(posedge Clk); #1;
    Count_ack = 0; Start = 0; ro_lvl = 0;
    chk("ack_valid", Count_valid, 0, 0);
    chk("ack_start_ignored", Busy, 0, 0);
    chk("count_kept", Count, cnt, 0);
  endtask

  initial begin
    longint c, o, ec, eo, tol;
    int p, g;
    Reset = 1; Start = 0; Count_ack = 0; Gate_cycles = '0; ro_wave_on = 0; ro_lvl = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_en", Ro_enable, 0, 0);
    chk("rst_busy", Busy, 0, 0);
    chk("rst_valid", Count_valid, 0, 0);
    chk("rst_count", Count, 0, 0);
    chk("rst_ovf", Overflow, 0, 0);
    #2 Reset = 0;

    // nominal: period 10, gate 1000, long ack delay
    ro_wave_on = 1; set_period(10);
    measure(1000, 0, 50, c, o);
    model(1000, 10, ec, eo, tol);
    chk("p10_count", c, ec, tol);
    chk("p10_ovf", o, eo, 0);

    // zero-length gate
    measure(0, 0, 3, c, o);
    chk("g0_count", c, 0, 0);
    chk("g0_ovf", o, 0, 0);

    // saturation, then sticky flag cleared by the next run
    set_period(4);
    measure(1200, 0, 4, c, o);
    model(1200, 4, ec, eo, tol);
    chk("sat_count", c, ec, tol);
    chk("sat_ovf", o, eo, 0);
    measure(20, 0, 2, c, o);
    model(20, 4, ec, eo, tol);
    chk("post_sat_count", c, ec, tol);
    chk("post_sat_ovf", o, eo, 0);

    // random periods and windows
    repeat (6) begin
      p = $urandom_range(4, 13);
      g = $urandom_range(20, 400);
      set_period(p);
      measure(g, 0, $urandom_range(0, 6), c, o);
      model(g, p, ec, eo, tol);
      chk("rand_count", c, ec, tol);
      chk("rand_ovf", o, eo, 0);
    end

    // reset mid-MEASURE between edges
    set_period(7);
    @(posedge Clk); #1;
    Gate_cycles = GW'(300); Start = 1;
    @(posedge Clk); #1;
    Start = 0;
    repeat (40) @(posedge Clk);
    #3 Reset = 1;
    #1;
    chk("rst_mid_en", Ro_enable, 0, 0);
    chk("rst_mid_busy", Busy, 0, 0);
    #1 Reset = 0;
    @(posedge Clk); #1;
    chk("rst_mid_valid", Count_valid, 0, 0);
    chk("rst_mid_count", Count, 0, 0);
    chk("rst_mid_busy2", Busy, 0, 0);
    measure(210, 0, 2, c, o);
    model(210, 7, ec, eo, tol);
    chk("after_rst_count", c, ec, tol);

    // constant high input
    ro_wave_on = 0; ro_lvl = 1;
    repeat (5) @(posedge Clk);
    measure(100, 1, 3, c, o);
    chk("const_count", c, 0, 0);
    ro_lvl = 0;
    repeat (5) @(posedge Clk);

    // single pulse before, inside and after the window
    measure(50, 2, 8, c, o);
    chk("pulse_count", c, 1, 0);
    chk("pulse_ovf", o, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
